alu_cmd_sequencer: RTL and testbench

//  Upstream front-end for the multi-cycle 8-bit ALU. Accepts one operation per valid/ready command,

---
 rtl/alu_cmd_sequencer_pkg.sv | 30 +++
 rtl/alu_cmd_sequencer_if.sv | 29 ++
 rtl/alu_cmd_sequencer_timer.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Purpose : shared opcodes, FSM state encoding and sizing helper for the ALU command sequencer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package alu_seq_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        ISSUE,
        HOLD,
        LOADM,
        WAIT,
        CAPT,
        ABORT,
        RESP
    } state_t;

    // Width of the shared timer; the WAIT window is the largest value it holds.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Purpose : command / response channel between an upstream requester and the ALU sequencer.
// Latency : n/a (wires only).
// Backpressure : cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
// Ports   : master = upstream (drives cmd_*, rsp_ready); slave = sequencer (drives cmd_ready, rsp_*).
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    op_t         cmd_op;
    logic [15:0] cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_of;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_of, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_of, rsp_err
    );

endinterface

// File: rtl/alu_cmd_sequencer_timer.sv
// Purpose : loadable down-counter with zero flag, shared by the HOLD, WAIT and CAPT phases.
// Latency : load/decrement take effect on the next clock edge; zero is combinational from the count.
// Backpressure : none; decrement saturates at zero.
// Ports   : clk, rst (sync, active-high), load + load_val, dec, zero.
module alu_seq_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Purpose : front-end for the multi-cycle 8-bit ALU; one operation in flight, owns ALU rst/start/sel/inbus.
// Latency : accept to rsp_valid = 3 + M_LOAD_DLY + (WAIT cycles) + RES_DLY cycles.
// Backpressure : cmd_ready only in IDLE; response held until rsp_ready.
// Ports   : clk, rst (sync, active-high), io (command/response slave), busy, alu_* pins to the ALU.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int M_LOAD_DLY = 2,
    parameter int RES_DLY    = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   io,
    output logic                 busy,
    output logic                 alu_rst,
    output logic                 alu_start,
    output logic [1:0]           alu_sel,
    output logic [15:0]          alu_inbus,
    input  logic [15:0]          alu_outbus,
    input  logic                 alu_finish,
    input  logic                 alu_of
);

    localparam int CW = cnt_width(TIMEOUT);

    // Timer preload values: the timer counts down to zero inclusive, so each
    // phase of N cycles is loaded with N-1.
    localparam logic [CW-1:0] HOLD_INIT = CW'((M_LOAD_DLY > 1) ? (M_LOAD_DLY - 2) : 0);
    localparam logic [CW-1:0] WAIT_INIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CAPT_INIT = CW'((RES_DLY > 0) ? (RES_DLY - 1) : 0);

    state_t        state;
    state_t        state_nxt;
    op_t           op_q;
    logic [15:0]   a_q;
    logic [7:0]    b_q;
    logic [15:0]   result_q;
    logic          of_sticky;
    logic          err_q;

    logic          tmr_load;
    logic          tmr_dec;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;
    logic          capture;

    alu_seq_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (io.cmd_valid) state_nxt = CLR;
            CLR:   state_nxt = ISSUE;
            ISSUE: state_nxt = (M_LOAD_DLY == 1) ? LOADM : HOLD;
            HOLD:  if (tmr_zero) state_nxt = LOADM;
            LOADM: state_nxt = WAIT;
            WAIT: begin
                // finish wins over a simultaneous timeout on the last WAIT cycle.
                if (alu_finish) begin
                    state_nxt = (RES_DLY == 0) ? RESP : CAPT;
                end else if (tmr_zero) begin
                    state_nxt = ABORT;
                end
            end
            CAPT:  if (tmr_zero) state_nxt = RESP;
            ABORT: state_nxt = RESP;
            RESP:  if (io.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register and the latched operands only.
    always_comb begin
        io.cmd_ready  = (state == IDLE);
        busy          = (state != IDLE);
        alu_rst       = rst || (state == CLR) || (state == ABORT);
        alu_start     = (state == ISSUE);
        alu_sel       = 2'b00;
        alu_inbus     = '0;
        case (state)
            CLR: alu_sel = op_q;
            ISSUE, HOLD: begin
                alu_sel   = op_q;
                alu_inbus = (op_q == OP_DIV) ? a_q : {8'h00, a_q[7:0]};
            end
            LOADM, WAIT, CAPT: begin
                alu_sel   = op_q;
                alu_inbus = {8'h00, b_q};
            end
            default: ;
        endcase
        io.rsp_valid  = (state == RESP);
        io.rsp_result = result_q;
        io.rsp_of     = of_sticky & ~op_q[1];
        io.rsp_err    = err_q;
    end

    // Timer sequencing and result capture strobe.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        capture  = 1'b0;
        case (state)
            ISSUE: begin
                tmr_load = 1'b1;
                tmr_val  = HOLD_INIT;
            end
            HOLD:  tmr_dec = 1'b1;
            LOADM: begin
                tmr_load = 1'b1;
                tmr_val  = WAIT_INIT;
            end
            WAIT: begin
                if (alu_finish) begin
                    if (RES_DLY == 0) begin
                        capture = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = CAPT_INIT;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CAPT: begin
                tmr_dec = 1'b1;
                capture = tmr_zero;
            end
            default: ;
        endcase
    end

    // Operand latches, overflow accumulation and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            of_sticky <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if ((state == IDLE) && io.cmd_valid) begin
                op_q <= io.cmd_op;
                a_q  <= io.cmd_a;
                b_q  <= io.cmd_b;
            end
            case (state)
                CLR: begin
                    result_q  <= '0;
                    of_sticky <= 1'b0;
                    err_q     <= 1'b0;
                end
                ISSUE, HOLD, LOADM, WAIT, CAPT: of_sticky <= of_sticky | alu_of;
                ABORT: begin
                    // A timed-out operation reports only the error flag.
                    result_q  <= '0;
                    of_sticky <= 1'b0;
                    err_q     <= 1'b1;
                end
                default: ;
            endcase
            if (capture) begin
                result_q <= alu_outbus;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose : self-checking bench for alu_cmd_sequencer against a behavioural multi-cycle ALU stand-in.
// Latency : stand-in ALU raises finish ALU_LAT cycles after it has loaded M.
// Backpressure : rsp_ready held low in one step to exercise response stalling.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int M_LOAD_DLY = 2;
    localparam int RES_DLY    = 1;
    localparam int TIMEOUT    = 64;
    localparam int ALU_LAT    = 3;
    localparam int W_NORMAL   = ALU_LAT + 1;

    typedef struct packed {
        logic [15:0] res;
        logic        of;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        alu_rst;
    logic        alu_start;
    logic [1:0]  alu_sel;
    logic [15:0] alu_inbus;
    logic [15:0] alu_outbus;
    logic        alu_finish;
    logic        alu_of;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if io();

    alu_cmd_sequencer #(
        .M_LOAD_DLY (M_LOAD_DLY),
        .RES_DLY    (RES_DLY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .busy       (busy),
        .alu_rst    (alu_rst),
        .alu_start  (alu_start),
        .alu_sel    (alu_sel),
        .alu_inbus  (alu_inbus),
        .alu_outbus (alu_outbus),
        .alu_finish (alu_finish),
        .alu_of     (alu_of)
    );

    function automatic exp_t mk(input logic [15:0] res, input logic of, input logic err);
        exp_t e;
        e.res = res;
        e.of  = of;
        e.err = err;
        return e;
    endfunction

    // Arithmetic of the stand-in ALU; div returns {remainder, quotient}.
    function automatic exp_t alu_ref(input op_t op, input logic [15:0] a, input logic [7:0] m);
        exp_t e;
        logic [7:0] s;
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] p;
        e = '0;
        case (op)
            OP_ADD: begin
                s     = a[7:0] + m;
                e.res = {8'h00, s};
                e.of  = (a[7] == m[7]) && (s[7] != a[7]);
            end
            OP_SUB: begin
                s     = a[7:0] - m;
                e.res = {8'h00, s};
                e.of  = (a[7] != m[7]) && (s[7] != a[7]);
            end
            OP_MUL: begin
                x     = {{8{a[7]}}, a[7:0]};
                y     = {{8{m[7]}}, m};
                p     = x * y;
                e.res = p;
            end
            default: begin
                if (m == 8'h00) begin
                    e.res = 16'hFFFF;
                end else begin
                    e.res[7:0]  = 8'(a / {8'h00, m});
                    e.res[15:8] = 8'(a % {8'h00, m});
                end
            end
        endcase
        return e;
    endfunction

    // Behavioural ALU: loads A on start, M from inbus M_LOAD_DLY cycles later,
    // then finishes ALU_LAT cycles after that. Mul/div pulse alu_of to show it is masked.
    logic        stuck;
    op_t         m_op;
    logic [15:0] m_a;
    logic [7:0]  m_m;
    logic        m_run;
    int          m_cnt;
    exp_t        alu_calc;

    assign alu_calc = alu_ref(m_op, m_a, m_m);

    always @(posedge clk) begin
        if (alu_rst) begin
            m_run      <= 1'b0;
            m_cnt      <= 0;
            alu_finish <= 1'b0;
            alu_of     <= 1'b0;
            alu_outbus <= '0;
            m_op       <= OP_ADD;
            m_a        <= '0;
            m_m        <= '0;
        end else begin
            alu_of <= 1'b0;
            if (alu_start) begin
                m_a   <= alu_inbus;
                m_op  <= alu_sel;
                m_run <= 1'b1;
                m_cnt <= 1;
            end else if (m_run) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == M_LOAD_DLY) m_m <= alu_inbus[7:0];
                if ((m_cnt == M_LOAD_DLY + ALU_LAT) && !stuck) begin
                    alu_finish <= 1'b1;
                    alu_outbus <= alu_calc.res;
                    alu_of     <= m_op[1] ? 1'b1 : alu_calc.of;
                    m_run      <= 1'b0;
                end
            end
        end
    end

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   lat    = 0;
    int   pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send(input op_t op, input logic [15:0] a, input logic [7:0] b,
                        input exp_t e, input logic push);
        int k;
        k = 0;
        io.cmd_valid = 1'b1;
        io.cmd_op    = op;
        io.cmd_a     = a;
        io.cmd_b     = b;
        while (!io.cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", io.cmd_ready, 1'b1);
        if (push) sb.push_back(e);
        lat    = 0;
        pulses = 0;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        lat = 1;
        if (alu_rst) pulses++;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, io.rsp_result, e.res);
            chk({tag, "_of"},     io.rsp_of,     e.of);
            chk({tag, "_err"},    io.rsp_err,    e.err);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!io.rsp_valid && k < 300) begin
            @(negedge clk);
            lat++;
            if (alu_rst) pulses++;
            k++;
        end
        chk({tag, "_rsp_valid"}, io.rsp_valid, 1'b1);
        if (io.rsp_valid) pop_cmp(tag);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         bad;
        int         crdy;
        int         seen;
        int         k;
        logic [15:0] r0;

        rst          = 1'b1;
        stuck        = 1'b0;
        io.cmd_valid = 1'b0;
        io.cmd_op    = OP_ADD;
        io.cmd_a     = '0;
        io.cmd_b     = '0;
        io.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_alu_rst",   alu_rst,       1'b1);
        chk("rst_cmd_ready", io.cmd_ready,  1'b1);
        chk("rst_busy",      busy,          1'b0);
        chk("rst_rsp_valid", io.rsp_valid,  1'b0);
        chk("rst_alu_start", alu_start,     1'b0);
        chk("rst_alu_sel",   alu_sel,       2'b00);
        chk("rst_alu_inbus", alu_inbus,     16'h0000);
        chk("rst_result",    io.rsp_result, 16'h0000);
        chk("rst_err",       io.rsp_err,    1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_alu_rst", alu_rst, 1'b0);

        // add 20 + 75, with latency and single clear pulse.
        send(OP_ADD, 16'd20, 8'd75, mk(16'h005F, 1'b0, 1'b0), 1'b1);
        wait_rsp("add_20_75");
        chk("add_latency", lat, 3 + M_LOAD_DLY + W_NORMAL + RES_DLY);
        chk("add_alu_rst_pulses", pulses, 1);

        // Signed overflow cases.
        send(OP_ADD, 16'd127, 8'd126, mk(16'h00FD, 1'b1, 1'b0), 1'b1);
        wait_rsp("add_127_126");
        send(OP_SUB, 16'h0080, 8'h01, mk(16'h007F, 1'b1, 1'b0), 1'b1);
        wait_rsp("sub_80_01");
        send(OP_SUB, 16'd20, 8'd75, mk(16'h00C9, 1'b0, 1'b0), 1'b1);
        wait_rsp("sub_20_75");

        // Multiplies: overflow pulses from the ALU must not reach rsp_of.
        send(OP_MUL, 16'h00E9, 8'h4B, mk(16'hF943, 1'b0, 1'b0), 1'b1);
        wait_rsp("mul_e9_4b");
        send(OP_MUL, 16'd40, 8'd12, mk(16'h01E0, 1'b0, 1'b0), 1'b1);
        wait_rsp("mul_40_12");

        // Divide uses the full 16-bit dividend: 1000 / 7 = 142 r 6.
        send(OP_DIV, 16'd1000, 8'd7, mk(16'h068E, 1'b0, 1'b0), 1'b1);
        wait_rsp("div_1000_7");

        // Timeout abort with a stuck ALU, then normal recovery.
        stuck = 1'b1;
        send(OP_ADD, 16'd5, 8'd6, mk(16'h0000, 1'b0, 1'b1), 1'b1);
        wait_rsp("abort");
        chk("abort_latency", lat, 2 + M_LOAD_DLY + TIMEOUT + 2);
        chk("abort_alu_rst_pulses", pulses, 2);
        stuck = 1'b0;
        send(OP_ADD, 16'd20, 8'd75, mk(16'h005F, 1'b0, 1'b0), 1'b1);
        wait_rsp("after_abort");

        // Reset during WAIT of a mul drops the operation.
        send(OP_MUL, 16'd40, 8'd12, mk(16'h0000, 1'b0, 1'b0), 1'b0);
        repeat (4) @(negedge clk);
        chk("midrst_busy",  busy,      1'b1);
        chk("midrst_inbus", alu_inbus, 16'h000C);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", io.cmd_ready, 1'b1);
        chk("midrst_busy_low",  busy,         1'b0);
        chk("midrst_rsp_valid", io.rsp_valid, 1'b0);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (io.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        send(OP_ADD, 16'd20, 8'd75, mk(16'h005F, 1'b0, 1'b0), 1'b1);
        wait_rsp("after_midrst");

        // Response stall with a second command waiting.
        io.rsp_ready = 1'b0;
        send(OP_ADD, 16'd1, 8'd2, mk(16'h0003, 1'b0, 1'b0), 1'b1);
        io.cmd_valid = 1'b1;
        io.cmd_op    = OP_SUB;
        io.cmd_a     = 16'd9;
        io.cmd_b     = 8'd4;
        crdy = 0;
        k    = 0;
        while (!io.rsp_valid && k < 300) begin
            if (io.cmd_ready) crdy++;
            @(negedge clk);
            k++;
        end
        chk("stall_rsp_valid", io.rsp_valid, 1'b1);
        r0  = io.rsp_result;
        bad = 0;
        repeat (5) begin
            if (!io.rsp_valid || (io.rsp_result !== r0) || io.rsp_err || io.rsp_of) bad++;
            if (io.cmd_ready) crdy++;
            @(negedge clk);
        end
        chk("stall_rsp_stable", bad,  0);
        chk("stall_cmd_ready",  crdy, 0);
        pop_cmp("stall_first");
        io.rsp_ready = 1'b1;
        sb.push_back(mk(16'h0005, 1'b0, 1'b0));
        @(negedge clk);
        chk("stall_rsp_dropped",   io.rsp_valid, 1'b0);
        chk("stall_next_accepted", io.cmd_ready, 1'b1);
        lat    = 0;
        pulses = 0;
        @(negedge clk);
        chk("stall_second_busy", busy, 1'b1);
        io.cmd_valid = 1'b0;
        lat = 1;
        if (alu_rst) pulses++;
        wait_rsp("stall_second");
        chk("stall_second_latency", lat, 3 + M_LOAD_DLY + W_NORMAL + RES_DLY);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
